// File: rtl/mult_pkg.sv
// Shared types and per-step constants for the 4x4 sequential multiplier controller.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [1:0] step_t;

    localparam step_t S0 = 2'd0;
    localparam step_t S3 = 2'd3;

    localparam logic [1:0] SHCTRL_0 = 2'b00;
    localparam logic [1:0] SHCTRL_2 = 2'b01;
    localparam logic [1:0] SHCTRL_4 = 2'b10;

    // Bit i set: step i takes the high digit of that operand.
    localparam logic [3:0] STEP_A_HI   = 4'b1010;
    localparam logic [3:0] STEP_B_HI   = 4'b1100;
    localparam logic [7:0] STEP_SHCTRL = {SHCTRL_4, SHCTRL_2, SHCTRL_2, SHCTRL_0};

    function automatic logic [1:0] digit_sel(input logic [3:0] v, input logic hi);
        return hi ? v[3:2] : v[1:0];
    endfunction

    function automatic logic [1:0] step_shctrl(input step_t s);
        return STEP_SHCTRL[{s, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/mult_step_seq.sv
// Step counter for the digit-serial multiply: S0..S3 in order, or only the non-zero
// digit pairs when MULT_ACC_SKIP_ZERO_EN is defined (mask captured on load).
module mult_step_seq
    import mult_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       adv,
`ifdef MULT_ACC_SKIP_ZERO_EN
    input  logic [3:0] a,
    input  logic [3:0] b,
`endif
    output step_t      step,
    output logic       last,
    output logic       empty
);

    step_t step_q, step_d;
    step_t first_step;

`ifdef MULT_ACC_SKIP_ZERO_EN
    logic [3:0] mask_q, mask_d;
    logic [3:0] load_mask;
    logic [3:0] rem;
    step_t      next_step;

    always_comb begin
        load_mask[0] = (|a[1:0]) & (|b[1:0]);
        load_mask[1] = (|a[3:2]) & (|b[1:0]);
        load_mask[2] = (|a[1:0]) & (|b[3:2]);
        load_mask[3] = (|a[3:2]) & (|b[3:2]);
        empty        = (load_mask == 4'b0000);

        first_step = S0;
        for (int i = 3; i >= 0; i--) begin
            if (load_mask[i]) first_step = step_t'(i);
        end

        // Active steps still ahead of the current one.
        rem = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (i > int'(step_q)) rem[i] = mask_q[i];
        end
        next_step = S0;
        for (int i = 3; i >= 0; i--) begin
            if (rem[i]) next_step = step_t'(i);
        end
        last = (rem == 4'b0000);

        mask_d = load ? load_mask : mask_q;
        step_d = step_q;
        if (load)     step_d = first_step;
        else if (adv) step_d = last ? S0 : next_step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mask_q <= 4'hF;
        else        mask_q <= mask_d;
    end
`else
    always_comb begin
        first_step = S0;
        empty      = 1'b0;
        last       = (step_q == S3);
        step_d     = step_q;
        if (load)     step_d = first_step;
        else if (adv) step_d = step_t'(step_q + 2'd1);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) step_q <= S0;
        else        step_q <= step_d;
    end

    assign step = step_q;

endmodule

// File: rtl/mult_acc_ctrl.sv
// Start/done controller and accumulator for the 4x4 multiplier: one cycle per active step,
// done pulses one cycle after the last step; start ignored while busy. Option: MULT_ACC_SKIP_ZERO_EN.
module mult_acc_ctrl
    import mult_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    output logic [1:0]       a_digit,
    output logic [1:0]       b_digit,
    output logic [1:0]       shctrl,
    input  logic [7:0]       pp_shifted,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] result
);

    state_t     state_q, state_d;
    logic [3:0] a_q, a_d, b_q, b_d;
    logic [7:0] acc_q, acc_d, res_q, res_d;
    logic       accept, adv;
    step_t      step;
    logic       last, empty;

    mult_step_seq u_seq (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .adv   (adv),
`ifdef MULT_ACC_SKIP_ZERO_EN
        .a     (a),
        .b     (b),
`endif
        .step  (step),
        .last  (last),
        .empty (empty)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        accept  = 1'b0;
        adv     = 1'b0;
        a_digit = 2'b00;
        b_digit = 2'b00;
        shctrl  = SHCTRL_0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) begin
                    accept = 1'b1;
                    a_d    = a;
                    b_d    = b;
                    acc_d  = 8'd0;
                    if (empty) begin
                        state_d = DONE;
                        res_d   = 8'd0;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                busy    = 1'b1;
                adv     = 1'b1;
                a_digit = digit_sel(a_q, STEP_A_HI[step]);
                b_digit = digit_sel(b_q, STEP_B_HI[step]);
                shctrl  = step_shctrl(step);
                // Max product is 225, so the 8-bit sum cannot wrap.
                acc_d   = acc_q + pp_shifted;
                if (last) begin
                    res_d   = acc_d;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            acc_q   <= 8'd0;
            res_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    assign result = ACC_W'(res_q);

endmodule

// File: tb/tb_mult_acc_ctrl.sv
// Bench for mult_acc_ctrl: directed vectors, expected products queued at issue, checked on done.
module tb_mult_acc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] a, b;
    logic [1:0] a_digit, b_digit, shctrl;
    logic [7:0] pp_shifted;
    logic       busy, done;
    logic [7:0] result;
    logic [3:0] tb_prod;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

`ifdef MULT_ACC_SKIP_ZERO_EN
    localparam int LAT_3X5  = 2;
    localparam int LAT_2X3  = 1;
`else
    localparam int LAT_3X5  = 4;
    localparam int LAT_2X3  = 4;
`endif

    mult_acc_ctrl #(.ACC_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .a_digit    (a_digit),
        .b_digit    (b_digit),
        .shctrl     (shctrl),
        .pp_shifted (pp_shifted),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;

    // Digit multiplier + shifter model.
    assign tb_prod = a_digit * b_digit;
    always_comb begin
        pp_shifted = 8'd0;
        case (shctrl)
            2'b00:   pp_shifted = {4'b0000, tb_prod};
            2'b01:   pp_shifted = {2'b00, tb_prod, 2'b00};
            2'b10:   pp_shifted = {tb_prod, 4'b0000};
            default: pp_shifted = 8'd0;
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                automatic logic [7:0] e = exp_q.pop_front();
                check("result", int'(result), int'(e));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, input int lat);
        int n;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (done) break;
            @(posedge clk);
            #1;
            n++;
        end
        check(name, n, lat);
        tick;
        @(negedge clk);
        check({name, "_pulse_end"}, int'(done), 0);
    endtask

    task automatic run_mul(input logic [3:0] ia, input logic [3:0] ib,
                           input logic [7:0] e, input int lat);
        exp_q.push_back(e);
        a = ia; b = ib; start = 1'b1;
        tick;
        start = 1'b0;
        a = ~ia; b = ~ib;
        wait_done("latency", lat);
    endtask

    task automatic run_trace(input logic [3:0] ia, input logic [3:0] ib, input logic [7:0] e,
                             input logic [7:0] sh, input logic [7:0] ad, input logic [7:0] bd);
        exp_q.push_back(e);
        a = ia; b = ib; start = 1'b1;
        tick;
        start = 1'b0;
        a = ~ia; b = ~ib;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("trace_busy",    int'(busy),    1);
            check("trace_shctrl",  int'(shctrl),  int'(sh[2*i +: 2]));
            check("trace_a_digit", int'(a_digit), int'(ad[2*i +: 2]));
            check("trace_b_digit", int'(b_digit), int'(bd[2*i +: 2]));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("trace_done", int'(done), 1);
        check("trace_busy_off", int'(busy), 0);
        tick;
        @(negedge clk);
        check("trace_done_off", int'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; a = 4'd0; b = 4'd0;
        #12;
        check("rst_busy",    int'(busy),    0);
        check("rst_done",    int'(done),    0);
        check("rst_result",  int'(result),  0);
        check("rst_a_digit", int'(a_digit), 0);
        check("rst_b_digit", int'(b_digit), 0);
        check("rst_shctrl",  int'(shctrl),  0);
        rst_n = 1'b1;
        tick;

        // 15x15: shctrl 00,01,01,10, all digits 3.
        run_trace(4'd15, 4'd15, 8'd225, 8'b10_01_01_00, 8'hFF, 8'hFF);
        // 9x6: a digits 1,2,1,2; b digits 2,2,1,1; operands changed during run.
        run_trace(4'd9, 4'd6, 8'd54, 8'b10_01_01_00, 8'b10_01_10_01, 8'b01_01_10_10);

        // Back-to-back: starts during busy are ignored, 3x5 accepted while done is high.
        exp_q.push_back(8'd54);
        a = 4'd9; b = 4'd6; start = 1'b1;
        tick;
        for (int i = 0; i < 3; i++) begin
            a = 4'd1; b = 4'd1; start = 1'b1;
            tick;
        end
        exp_q.push_back(8'd15);
        a = 4'd3; b = 4'd5; start = 1'b1;
        tick;
        @(negedge clk);
        check("b2b_done_first", int'(done), 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 4'd0; b = 4'd0;
        @(negedge clk);
        check("b2b_no_gap_busy", int'(busy), 1);
        check("b2b_no_gap_done", int'(done), 0);
        begin
            int n;
            n = 1;
            while (n < 20) begin
                if (done) break;
                @(posedge clk);
                #1;
                @(negedge clk);
                if (done) break;
                n++;
            end
            check("b2b_latency", n, LAT_3X5);
        end
        tick;

        // Reset mid-run, after S1 of 15x15.
        a = 4'd15; b = 4'd15; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        check("midrst_busy",    int'(busy),    0);
        check("midrst_done",    int'(done),    0);
        check("midrst_result",  int'(result),  0);
        check("midrst_a_digit", int'(a_digit), 0);
        check("midrst_b_digit", int'(b_digit), 0);
        check("midrst_shctrl",  int'(shctrl),  0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        run_mul(4'd2, 4'd3, 8'd6, LAT_2X3);

`ifdef MULT_ACC_SKIP_ZERO_EN
        run_mul(4'd1, 4'd3, 8'd3, 1);
        run_mul(4'd0, 4'd12, 8'd0, 0);
        exp_q.push_back(8'd32);
        a = 4'd4; b = 4'd8; start = 1'b1;
        tick;
        start = 1'b0;
        @(negedge clk);
        check("skip_s3_shctrl", int'(shctrl), 2);
        wait_done("skip_s3_latency", 0);
`else
        run_mul(4'd0, 4'd12, 8'd0, 4);
        run_mul(4'd15, 4'd1, 8'd15, 4);
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
